tengig_eth_loop_arb: RTL and testbench
======================================

// Module: tengig_eth_loop_arb
// PURPOSE
//  Frame-level arbiter and sequencer in front of the 10GE MAC-address swapper.
//  - Shares the swapper input between two AXI4-Stream sources: shell TX (TXP) and RX loopback (LPB).
//  - Drives the swapper enable so it changes only between frames, after the swapper pipeline has drained.
//  - Sinks loopback traffic when loopback is disabled.
// PARAMETERS
//  SWAP_LAT  2   swapper pipeline depth, in accepted beats, before an enable change is safe
//  CNT_W     16  width of the saturating frame and drop counters
// PORTS
//  piEthCoreClk           in   1   core clock; everything is synchronous to its rising edge
//  piEthCoreRst_n         in   1   asynchronous, active-low reset
//  piMMIO_LoopEn          in   1   1 = grant LPB frames; 0 = drop LPB frames
//  piMMIO_SwapEn          in   1   1 = swap MACs on LPB frames (TXP frames are never swapped)
//  piTXP_Arb_Axis_tdata   in   64  TXP stream data
//  piTXP_Arb_Axis_tkeep   in   8   TXP byte enables
//  piTXP_Arb_Axis_tlast   in   1   TXP end of frame
//  piTXP_Arb_Axis_tvalid  in   1   TXP valid
//  poARB_Txp_Axis_tready  out  1   TXP ready
//  piLPB_Arb_Axis_tdata   in   64  loopback stream data
//  piLPB_Arb_Axis_tkeep   in   8   loopback byte enables
//  piLPB_Arb_Axis_tlast   in   1   loopback end of frame
//  piLPB_Arb_Axis_tvalid  in   1   loopback valid
//  poARB_Lpb_Axis_tready  out  1   loopback ready
//  poARB_Swap_Axis_tdata  out  64  data to swapper
//  poARB_Swap_Axis_tkeep  out  8   byte enables to swapper
//  poARB_Swap_Axis_tlast  out  1   end of frame to swapper
//  poARB_Swap_Axis_tvalid out  1   valid to swapper
//  piSWAP_Arb_Axis_tready in   1   swapper ready
//  poARB_Swap_SwapEn      out  1   registered swap enable to swapper
//  poARB_TxpFrmCnt        out  CNT_W  TXP frames forwarded (saturating)
//  poARB_LpbFrmCnt        out  CNT_W  LPB frames forwarded (saturating)
//  poARB_LpbDropCnt       out  CNT_W  LPB frames dropped (saturating)
// BEHAVIOUR
//  Reset:
//   - FSM = IDLE; grant = none; poARB_Swap_SwapEn = 0; all counters = 0.
//   - RR pointer = TXP first.
//   - Output tvalid = 0 and both input treadys = 0 while reset is asserted.
//  Datapath:
//   - Zero latency: the output is a combinational mux of the granted source.
//   - Granted source tready = piSWAP_Arb_Axis_tready. Non-granted treadys = 0 (except LPB in DROP).
//   - A beat is accepted when tvalid & tready on the output.
//  MMIO sampling:
//   - piMMIO_LoopEn and piMMIO_SwapEn are sampled only in IDLE.
//   - Changes made mid-frame take effect from the next arbitration.
//  FSM states: IDLE, DRAIN, FWD, DROP.
//   - IDLE:
//     - Requesters are TXP (tvalid) and LPB (tvalid & LoopEn). Round-robin pick; the pointer flips to the other source after each grant.
//     - LPB valid & !LoopEn & no TXP request -> DROP.
//     - Target enable tgt = (grant == LPB) & SwapEn.
//     - tgt == poARB_Swap_SwapEn -> FWD in the next cycle; otherwise -> DRAIN with count = 0.
//   - DRAIN:
//     - Both treadys = 0; output tvalid = 0.
//     - count increments on each cycle with piSWAP_Arb_Axis_tready = 1.
//     - At count == SWAP_LAT-1 with ready: poARB_Swap_SwapEn <= tgt, then -> FWD.
//   - FWD:
//     - Forward the granted source.
//     - Accepted beat with tlast=1: increment that source's frame counter, -> IDLE.
//   - DROP:
//     - poARB_Lpb_Axis_tready = 1; no output.
//     - Accepted LPB tlast: increment LpbDropCnt, -> IDLE.
//  Rules:
//   - Grant never changes mid-frame.
//   - Frames never interleave; back-to-back frames from the same source lose one IDLE cycle.
//   - A frame with tkeep = 0 beats is forwarded unchanged (no filtering).
//   - Counters hold at 2^CNT_W-1.
//   - Simultaneous TXP and LPB requests go to the RR pointer's source.
//  Reset mid-frame: the frame is truncated (no tlast is emitted); the FSM restarts in IDLE.
// TESTING
//  T1 LoopEn=0, 3 TXP frames of 4 beats, ready=1 -> 12 beats out, gaps of 1 idle cycle, SwapEn stays 0, TxpFrmCnt=3.
//  T2 LoopEn=1, SwapEn=1, TXP and LPB both always valid, 2-beat frames -> alternating TXP/LPB.
//     - SwapEn toggles only after 2 ready cycles of DRAIN.
//     - Each frame is intact.
//  T3 LoopEn=0, LPB 5-beat frame -> poARB_Lpb_Axis_tready=1 for 5 beats, no output beats, LpbDropCnt=1.
//  T4 Random ready (50%) during FWD and DRAIN -> no data loss or duplication; DRAIN lasts exactly SWAP_LAT ready cycles.
//  T5 Toggle LoopEn at beat 2 of a 6-beat LPB frame -> frame completes, next LPB frame is dropped.
//  T6 Assert reset at beat 3 of a frame -> outputs = reset values immediately.
//     - Counters = 0 after release.
//     - The next frame starts cleanly.

Source files
------------

// File: rtl/tengig_eth_loop_arb.sv
// rtl/tengig_eth_loop_arb.sv - frame-level TXP/loopback arbiter and swap-enable sequencer for the 10GE MAC swapper
//
// Shares the swapper input between shell TX (TXP) and RX loopback (LPB) one whole
// frame at a time. The swap enable is changed only between frames, after the swapper
// pipeline has drained. When loopback is disabled, LPB frames are sunk and counted.
//
// Ports:
//   piEthCoreClk / piEthCoreRst_n   core clock, asynchronous active-low reset
//   piMMIO_LoopEn / piMMIO_SwapEn   loopback grant / LPB MAC-swap enables (sampled in IDLE)
//   piTXP_Arb_Axis_*                TXP source stream, poARB_Txp_Axis_tready its ready
//   piLPB_Arb_Axis_*                LPB source stream, poARB_Lpb_Axis_tready its ready
//   poARB_Swap_Axis_*               stream to swapper, piSWAP_Arb_Axis_tready its ready
//   poARB_Swap_SwapEn               registered swap enable to swapper
//   poARB_TxpFrmCnt / poARB_LpbFrmCnt / poARB_LpbDropCnt   saturating frame counters
module tengig_eth_loop_arb #(
  parameter int SWAP_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic             piEthCoreClk,
  input  logic             piEthCoreRst_n,
  input  logic             piMMIO_LoopEn,
  input  logic             piMMIO_SwapEn,
  input  logic [63:0]      piTXP_Arb_Axis_tdata,
  input  logic [7:0]       piTXP_Arb_Axis_tkeep,
  input  logic             piTXP_Arb_Axis_tlast,
  input  logic             piTXP_Arb_Axis_tvalid,
  output logic             poARB_Txp_Axis_tready,
  input  logic [63:0]      piLPB_Arb_Axis_tdata,
  input  logic [7:0]       piLPB_Arb_Axis_tkeep,
  input  logic             piLPB_Arb_Axis_tlast,
  input  logic             piLPB_Arb_Axis_tvalid,
  output logic             poARB_Lpb_Axis_tready,
  output logic [63:0]      poARB_Swap_Axis_tdata,
  output logic [7:0]       poARB_Swap_Axis_tkeep,
  output logic             poARB_Swap_Axis_tlast,
  output logic             poARB_Swap_Axis_tvalid,
  input  logic             piSWAP_Arb_Axis_tready,
  output logic             poARB_Swap_SwapEn,
  output logic [CNT_W-1:0] poARB_TxpFrmCnt,
  output logic [CNT_W-1:0] poARB_LpbFrmCnt,
  output logic [CNT_W-1:0] poARB_LpbDropCnt
);

  localparam int               DCW        = (SWAP_LAT > 1) ? $clog2(SWAP_LAT) : 1;
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(SWAP_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic             SRC_TXP    = 1'b0;
  localparam logic             SRC_LPB    = 1'b1;

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_FWD, S_DROP} state_t;

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             rr_q, rr_d;
  logic             tgt_q, tgt_d;
  logic             swap_en_q, swap_en_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0] txp_cnt_q, txp_cnt_d;
  logic [CNT_W-1:0] lpb_cnt_q, lpb_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  logic txp_req, lpb_req, idle_pick, idle_tgt;
  logic sel_valid, sel_last, fwd_accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  assign txp_req   = piTXP_Arb_Axis_tvalid;
  assign lpb_req   = piLPB_Arb_Axis_tvalid & piMMIO_LoopEn;
  // Contention goes to the round-robin pointer; otherwise the lone requester wins.
  assign idle_pick = (txp_req & lpb_req) ? rr_q : (lpb_req ? SRC_LPB : SRC_TXP);
  assign idle_tgt  = (idle_pick == SRC_LPB) & piMMIO_SwapEn;

  assign sel_valid  = (grant_q == SRC_LPB) ? piLPB_Arb_Axis_tvalid : piTXP_Arb_Axis_tvalid;
  assign sel_last   = (grant_q == SRC_LPB) ? piLPB_Arb_Axis_tlast  : piTXP_Arb_Axis_tlast;
  assign fwd_accept = (state_q == S_FWD) & sel_valid & piSWAP_Arb_Axis_tready;

  // Zero-latency datapath: data/keep/last follow the grant, only tvalid is state-gated.
  assign poARB_Swap_Axis_tdata = (grant_q == SRC_LPB) ? piLPB_Arb_Axis_tdata : piTXP_Arb_Axis_tdata;
  assign poARB_Swap_Axis_tkeep = (grant_q == SRC_LPB) ? piLPB_Arb_Axis_tkeep : piTXP_Arb_Axis_tkeep;
  assign poARB_Swap_Axis_tlast = sel_last;

  always_comb begin
    state_d                = state_q;
    grant_d                = grant_q;
    rr_d                   = rr_q;
    tgt_d                  = tgt_q;
    swap_en_d              = swap_en_q;
    drain_d                = drain_q;
    txp_cnt_d              = txp_cnt_q;
    lpb_cnt_d              = lpb_cnt_q;
    drop_cnt_d             = drop_cnt_q;
    poARB_Swap_Axis_tvalid = 1'b0;
    poARB_Txp_Axis_tready  = 1'b0;
    poARB_Lpb_Axis_tready  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (txp_req | lpb_req) begin
          grant_d = idle_pick;
          rr_d    = ~idle_pick;
          tgt_d   = idle_tgt;
          if (idle_tgt == swap_en_q) begin
            state_d = S_FWD;
          end else begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end else if (piLPB_Arb_Axis_tvalid) begin
          // Only reachable with LoopEn low: LPB has data but may not be granted.
          state_d = S_DROP;
        end
      end
      S_DRAIN: begin
        // Swapper advances only on ready cycles, so only those count toward the flush.
        if (piSWAP_Arb_Axis_tready) begin
          if (drain_q == DRAIN_LAST) begin
            swap_en_d = tgt_q;
            state_d   = S_FWD;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      S_FWD: begin
        poARB_Swap_Axis_tvalid = sel_valid;
        poARB_Txp_Axis_tready  = (grant_q == SRC_TXP) & piSWAP_Arb_Axis_tready;
        poARB_Lpb_Axis_tready  = (grant_q == SRC_LPB) & piSWAP_Arb_Axis_tready;
        if (fwd_accept & sel_last) begin
          if (grant_q == SRC_LPB) lpb_cnt_d = sat_inc(lpb_cnt_q);
          else                    txp_cnt_d = sat_inc(txp_cnt_q);
          state_d = S_IDLE;
        end
      end
      S_DROP: begin
        poARB_Lpb_Axis_tready = 1'b1;
        if (piLPB_Arb_Axis_tvalid & piLPB_Arb_Axis_tlast) begin
          drop_cnt_d = sat_inc(drop_cnt_q);
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge piEthCoreClk or negedge piEthCoreRst_n) begin
    if (!piEthCoreRst_n) begin
      state_q    <= S_IDLE;
      grant_q    <= SRC_TXP;
      rr_q       <= SRC_TXP;
      tgt_q      <= 1'b0;
      swap_en_q  <= 1'b0;
      drain_q    <= '0;
      txp_cnt_q  <= '0;
      lpb_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_q       <= rr_d;
      tgt_q      <= tgt_d;
      swap_en_q  <= swap_en_d;
      drain_q    <= drain_d;
      txp_cnt_q  <= txp_cnt_d;
      lpb_cnt_q  <= lpb_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign poARB_Swap_SwapEn = swap_en_q;
  assign poARB_TxpFrmCnt   = txp_cnt_q;
  assign poARB_LpbFrmCnt   = lpb_cnt_q;
  assign poARB_LpbDropCnt  = drop_cnt_q;

endmodule

// File: tb/tb_tengig_eth_loop_arb.sv
// tb/tb_tengig_eth_loop_arb.sv - randomized self-checking bench for tengig_eth_loop_arb
module tb_tengig_eth_loop_arb;

  localparam int SWAP_LAT = 2;
  localparam int CNT_W    = 5;
  localparam int CMAX     = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  logic             clk, rst_n, loop_en, swap_cfg;
  logic [63:0]      txp_data, lpb_data, o_data;
  logic [7:0]       txp_keep, lpb_keep, o_keep;
  logic             txp_last, txp_valid, txp_ready;
  logic             lpb_last, lpb_valid, lpb_ready;
  logic             o_last, o_valid, sw_ready, sw_en;
  logic [CNT_W-1:0] txp_cnt, lpb_cnt, drop_cnt;

  tengig_eth_loop_arb #(.SWAP_LAT(SWAP_LAT), .CNT_W(CNT_W)) dut (
    .piEthCoreClk           (clk),
    .piEthCoreRst_n         (rst_n),
    .piMMIO_LoopEn          (loop_en),
    .piMMIO_SwapEn          (swap_cfg),
    .piTXP_Arb_Axis_tdata   (txp_data),
    .piTXP_Arb_Axis_tkeep   (txp_keep),
    .piTXP_Arb_Axis_tlast   (txp_last),
    .piTXP_Arb_Axis_tvalid  (txp_valid),
    .poARB_Txp_Axis_tready  (txp_ready),
    .piLPB_Arb_Axis_tdata   (lpb_data),
    .piLPB_Arb_Axis_tkeep   (lpb_keep),
    .piLPB_Arb_Axis_tlast   (lpb_last),
    .piLPB_Arb_Axis_tvalid  (lpb_valid),
    .poARB_Lpb_Axis_tready  (lpb_ready),
    .poARB_Swap_Axis_tdata  (o_data),
    .poARB_Swap_Axis_tkeep  (o_keep),
    .poARB_Swap_Axis_tlast  (o_last),
    .poARB_Swap_Axis_tvalid (o_valid),
    .piSWAP_Arb_Axis_tready (sw_ready),
    .poARB_Swap_SwapEn      (sw_en),
    .poARB_TxpFrmCnt        (txp_cnt),
    .poARB_LpbFrmCnt        (lpb_cnt),
    .poARB_LpbDropCnt       (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  beat_t txp_q[$];
  beat_t lpb_q[$];
  beat_t exp_q[$];
  int    fid = 0;
  int    rdy_pct = 100;

  int cyc = 0, end_cyc = 0, rdy_cnt = 0, out_beats = 0, lpb_sink = 0, drain_events = 0;
  bit in_frame = 0, have_end = 0, skip = 0, chk_drain = 0, chk_gap = 0;
  logic prev_sw = 1'b0;

  // Builds one frame; its source bit, frame id and beat index are embedded in tdata.
  task automatic gen_frame(input bit src, input int len, input bit expect_out);
    beat_t x;
    for (int b = 0; b < len; b++) begin
      x.d         = {$urandom(), $urandom()};
      x.d[63]     = src;
      x.d[62:56]  = fid[6:0];
      x.d[55:48]  = b[7:0];
      x.k         = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      x.l         = (b == len - 1);
      if (src) lpb_q.push_back(x);
      else     txp_q.push_back(x);
      if (expect_out) exp_q.push_back(x);
    end
    fid++;
  endtask

  // Reference order with both sources continuously offering frames: strict alternation
  // starting with TXP, then whatever remains. Returns the number of source switches.
  task automatic gen_rr(input int nt, input int nl, input int lmin, input int lmax, output int switches);
    bit p = 1'b0;
    bit s, last_src = 1'b0, first = 1'b1;
    switches = 0;
    while (nt > 0 || nl > 0) begin
      s = (nt > 0 && nl > 0) ? p : (nl > 0);
      p = !s;
      if (!first && s != last_src) switches++;
      first    = 1'b0;
      last_src = s;
      gen_frame(s, int'($urandom_range(lmin, lmax)), 1'b1);
      if (s) nl--;
      else   nt--;
    end
  endtask

  initial begin
    bit hs;
    txp_valid = 1'b0; txp_data = '0; txp_keep = '0; txp_last = 1'b0;
    forever begin
      @(negedge clk);
      hs = txp_valid && txp_ready;
      @(posedge clk);
      #1;
      if (hs && txp_q.size() > 0) void'(txp_q.pop_front());
      if (txp_q.size() > 0) begin
        {txp_data, txp_keep, txp_last} = txp_q[0];
        txp_valid = 1'b1;
      end else begin
        txp_valid = 1'b0;
      end
    end
  end

  initial begin
    bit hs;
    lpb_valid = 1'b0; lpb_data = '0; lpb_keep = '0; lpb_last = 1'b0;
    forever begin
      @(negedge clk);
      hs = lpb_valid && lpb_ready;
      @(posedge clk);
      #1;
      if (hs && lpb_q.size() > 0) void'(lpb_q.pop_front());
      if (lpb_q.size() > 0) begin
        {lpb_data, lpb_keep, lpb_last} = lpb_q[0];
        lpb_valid = 1'b1;
      end else begin
        lpb_valid = 1'b0;
      end
    end
  end

  initial begin
    sw_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      sw_ready = (int'($urandom_range(0, 99)) < rdy_pct);
    end
  end

  // Output monitor / scoreboard.
  initial begin
    beat_t got, e;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n) begin
        if (chk_drain && (sw_en !== prev_sw)) begin
          drain_events++;
          check("drain_ready_cycles", 128'(rdy_cnt), 128'(SWAP_LAT));
        end
        if (o_valid && sw_ready) begin
          got = {o_data, o_keep, o_last};
          e   = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          out_beats++;
          check("beat", 128'(got), 128'(e));
          check("beat_swapen", 128'(sw_en), 128'(o_data[63] & swap_cfg));
          if (chk_gap && !in_frame && have_end) check("frame_gap", 128'(cyc - end_cyc), 128'(2));
          in_frame = !o_last;
          if (o_last) begin
            end_cyc  = cyc;
            have_end = 1'b1;
            rdy_cnt  = 0;
            skip     = 1'b1;
          end
        end else if (skip) begin
          skip = 1'b0;
        end else if (sw_ready) begin
          rdy_cnt++;
        end
        if (lpb_valid && lpb_ready && !o_valid) lpb_sink++;
      end
      prev_sw = sw_en;
    end
  end

  task automatic clear_mon();
    out_beats = 0; lpb_sink = 0; drain_events = 0; rdy_cnt = 0;
    in_frame = 1'b0; have_end = 1'b0; skip = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    txp_q.delete(); lpb_q.delete(); exp_q.delete();
    clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_done(input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      done = (txp_q.size() == 0) && (lpb_q.size() == 0) && (exp_q.size() == 0);
    end
    check("complete", 128'(done), 128'(1));
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_beats(input int n, input int budget);
    bit done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk);
      done = (out_beats >= n);
    end
    check("beats_reached", 128'(done), 128'(1));
  endtask

  initial begin
    int sw;
    rst_n = 1'b0; loop_en = 1'b0; swap_cfg = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_valid", 128'(o_valid), 128'(0));
    check("rst_txp_ready", 128'(txp_ready), 128'(0));
    check("rst_lpb_ready", 128'(lpb_ready), 128'(0));
    check("rst_swapen", 128'(sw_en), 128'(0));
    check("rst_counters", 128'({txp_cnt, lpb_cnt, drop_cnt}), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // T1: TXP only, back-to-back frames separated by exactly one idle cycle.
    chk_gap = 1'b1;
    for (int f = 0; f < 3; f++) gen_frame(1'b0, 4, 1'b1);
    wait_done(200);
    chk_gap = 1'b0;
    check("t1_beats", 128'(out_beats), 128'(12));
    check("t1_txp_cnt", 128'(txp_cnt), 128'(3));
    check("t1_swapen", 128'(sw_en), 128'(0));

    // T2: both sources saturated, swap on LPB -> alternation with a drain per switch.
    do_reset();
    loop_en = 1'b1; swap_cfg = 1'b1; chk_drain = 1'b1;
    gen_rr(4, 4, 2, 2, sw);
    wait_done(400);
    check("t2_txp_cnt", 128'(txp_cnt), 128'(4));
    check("t2_lpb_cnt", 128'(lpb_cnt), 128'(4));
    check("t2_drains", 128'(drain_events), 128'(sw));

    // T3: loopback disabled, LPB frame is sunk.
    do_reset();
    chk_drain = 1'b0; loop_en = 1'b0; swap_cfg = 1'b0;
    gen_frame(1'b1, 5, 1'b0);
    wait_done(200);
    check("t3_sink_beats", 128'(lpb_sink), 128'(5));
    check("t3_out_beats", 128'(out_beats), 128'(0));
    check("t3_drop_cnt", 128'(drop_cnt), 128'(1));
    check("t3_lpb_cnt", 128'(lpb_cnt), 128'(0));

    // T4: random ready, random lengths and keeps.
    do_reset();
    rdy_pct = 50; loop_en = 1'b1; swap_cfg = 1'b1; chk_drain = 1'b1;
    gen_rr(6, 5, 1, 5, sw);
    wait_done(2000);
    check("t4_txp_cnt", 128'(txp_cnt), 128'(6));
    check("t4_lpb_cnt", 128'(lpb_cnt), 128'(5));
    check("t4_drains", 128'(drain_events), 128'(sw));
    rdy_pct = 100; chk_drain = 1'b0;

    // T5: LoopEn drops mid-frame; current frame completes, next LPB frame is dropped.
    do_reset();
    loop_en = 1'b1; swap_cfg = 1'b0;
    gen_frame(1'b1, 6, 1'b1);
    gen_frame(1'b1, 6, 1'b0);
    wait_beats(2, 200);
    loop_en = 1'b0;
    wait_done(300);
    check("t5_lpb_cnt", 128'(lpb_cnt), 128'(1));
    check("t5_drop_cnt", 128'(drop_cnt), 128'(1));
    check("t5_sink_beats", 128'(lpb_sink), 128'(6));

    // Counter saturation.
    do_reset();
    loop_en = 1'b0;
    for (int f = 0; f < CMAX + 4; f++) gen_frame(1'b0, 1, 1'b1);
    for (int f = 0; f < CMAX + 4; f++) gen_frame(1'b1, 1, 1'b0);
    wait_done(2000);
    check("sat_txp_cnt", 128'(txp_cnt), 128'(CMAX));
    check("sat_drop_cnt", 128'(drop_cnt), 128'(CMAX));

    // T6: reset in the middle of a swapped LPB frame.
    do_reset();
    loop_en = 1'b1; swap_cfg = 1'b1;
    gen_frame(1'b1, 4, 1'b1);
    gen_frame(1'b1, 6, 1'b1);
    wait_beats(7, 300);
    #2;
    check("t6_swapen_pre", 128'(sw_en), 128'(1));
    check("t6_lpb_cnt_pre", 128'(lpb_cnt), 128'(1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 128'(o_valid), 128'(0));
    check("t6_rst_readys", 128'({txp_ready, lpb_ready}), 128'(0));
    check("t6_rst_swapen", 128'(sw_en), 128'(0));
    txp_q.delete(); lpb_q.delete(); exp_q.delete();
    clear_mon();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("t6_counters", 128'({txp_cnt, lpb_cnt, drop_cnt}), 128'(0));
    gen_frame(1'b0, 3, 1'b1);
    wait_done(200);
    check("t6_txp_cnt", 128'(txp_cnt), 128'(1));
    check("t6_beats", 128'(out_beats), 128'(3));
    check("t6_lpb_cnt", 128'(lpb_cnt), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
